dma_copy: RTL and testbench
===========================

DMA_COPY -- requirements
Module: dma_copy

Interface
REQ-001 SHALL: clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-high reset; it acts immediately, without waiting for clk.
REQ-003 SHALL: start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-004 SHALL: src_addr  input  16  first source byte address; latched on accepted start.
REQ-005 SHALL: dst_addr  input  16  first destination byte address; latched on accepted start.
REQ-006 SHALL: length  input  16  byte count; latched on accepted start.
REQ-007 SHALL: bus_address  output  16  address driven into memory_bus address.
REQ-008 SHALL: bus_data_out  output  8  write data driven into memory_bus data_in.
REQ-009 SHALL: bus_data_in  input  8  read data from memory_bus data_out.
REQ-010 SHALL: bus_write_enable  output  1  drives memory_bus write_enable.
REQ-011 SHALL: busy  output  1  high in every state except IDLE.
REQ-012 SHALL: done  output  1  one-cycle pulse when a transfer completes.
REQ-013 SHALL: fill_mode  input  1  with DMA_FILL_EN, selects fill instead of copy; latched on start.
REQ-014 SHALL: fill_value  input  8  with DMA_FILL_EN, the byte written in fill mode; latched on start.

Function
REQ-015 SHALL: states IDLE, READ_ADDR, READ_WAIT, WRITE, WRITE_HOLD, DONE.
REQ-016 SHALL: IDLE + start=1 -> latch inputs; length=0 -> DONE, otherwise -> READ_ADDR.
REQ-017 SHALL: READ_ADDR -> drive bus_address=current source, bus_write_enable=0; -> READ_WAIT.
REQ-018 SHALL: READ_WAIT -> hold source address; capture bus_data_in into the data register at the end of the cycle; -> WRITE.
REQ-019 SHALL: WRITE -> drive bus_address=current destination, bus_data_out=captured byte, bus_write_enable=1 for exactly one cycle; -> WRITE_HOLD.
REQ-020 SHALL: WRITE_HOLD -> keep address and data stable with bus_write_enable=0, so the bank commits its registered write; then increment source, increment destination, decrement the remaining count.
REQ-021 SHALL: WRITE_HOLD exit: remaining count becomes 0 -> DONE; otherwise -> READ_ADDR.
REQ-022 SHALL: DONE -> done=1 for one cycle, bus_write_enable=0; -> IDLE.
REQ-023 SHALL: copy throughput is exactly 4 clk cycles per byte; a transfer of N>0 bytes runs from the accepted start to the done pulse in 4N+1 cycles.
REQ-024 SHALL: addresses ascend and wrap modulo 2^16 (0xFFFF+1 -> 0x0000); the copy is always forward, and overlapping regions are not corrected.
REQ-025 SHALL: start while busy=1 is ignored; there is no queueing.
REQ-026 SHALL: bus_address is 0x0000 and bus_data_out is 0x00 in IDLE and DONE.

Reset
REQ-027 SHALL: while reset=1, state=IDLE, busy=0, done=0, bus_write_enable=0, bus_address=0x0000, bus_data_out=0x00, and all internal counters=0.
REQ-028 SHALL: reset mid-transfer aborts immediately; bytes already written stay written, no partial write is issued, and no done pulse is produced.

Configuration
REQ-029 SHALL: macro DMA_FILL_EN defined -> fill_mode=1 skips READ_ADDR and READ_WAIT (WRITE -> WRITE_HOLD -> WRITE ...), writes the latched fill_value and does not advance the source; throughput is 2 cycles per byte and N bytes complete in 2N+1 cycles.
REQ-030 SHALL: macro DMA_FILL_EN undefined -> the fill_mode and fill_value ports exist but are ignored, and every transfer is a copy.

Verification
REQ-031 SHALL: RAM 0x0010..0x0013={11,22,33,44}, start src=0x0010 dst=0x0100 len=4 -> RAM 0x0100..0x0103={11,22,33,44}; done pulses 17 cycles after start; exactly 4 write_enable pulses.
REQ-032 SHALL: src=0x4000 (ROM) dst=0x0000 len=8 -> RAM 0x0000..0x0007 equals ROM bytes 0..7.
REQ-033 SHALL: len=0 -> done one cycle after start; write_enable never asserted; busy high for one cycle.
REQ-034 SHALL: src=0xFFFF len=2 -> bus_address sequence 0xFFFF then 0x0000 for reads.
REQ-035 SHALL: reset asserted during the WRITE of byte 3 of 8 -> bus_write_enable falls asynchronously; only bytes 0-1 (and byte 2 only if its WRITE_HOLD already finished) are changed; no done pulse.
REQ-036 SHALL: with DMA_FILL_EN, fill_mode=1, fill_value=0xA5, dst=0x0020, len=3 -> RAM 0x0020..0x0022=0xA5; done pulses 7 cycles after start; a second start while busy is ignored.

Source files
------------

// File: rtl/dma_copy.sv
// Byte-serial DMA engine: copies `length` bytes from src_addr to dst_addr over a
// single-port memory bus. Optional fill mode is compiled in with `DMA_FILL_EN.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for start; bus parked at 0
// READ_ADDR  | present source address to the bus
// READ_WAIT  | hold source address, capture read byte at cycle end
// WRITE      | present destination address and data, write_enable high
// WRITE_HOLD | keep address/data stable, advance pointers and count
// DONE       | one-cycle done pulse
module dma_copy (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] src_addr,
  input  logic [15:0] dst_addr,
  input  logic [15:0] length,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_data_out,
  input  logic [7:0]  bus_data_in,
  output logic        bus_write_enable,
  output logic        busy,
  output logic        done,
  input  logic        fill_mode,
  input  logic [7:0]  fill_value
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READ_ADDR  = 3'd1,
    READ_WAIT  = 3'd2,
    WRITE      = 3'd3,
    WRITE_HOLD = 3'd4,
    DONE       = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] src_q, dst_q, remaining_q;
  logic [7:0]  data_q;
  logic        fill_sel;
  logic        fill_q;

`ifdef DMA_FILL_EN
  assign fill_sel = fill_mode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fill_q <= 1'b0;
    else if (state_q == IDLE && start)
      fill_q <= fill_mode;
  end
`else
  logic unused_fill;
  assign fill_sel    = 1'b0;
  assign fill_q      = 1'b0;
  assign unused_fill = ^{fill_mode, fill_value};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      src_q       <= 16'h0000;
      dst_q       <= 16'h0000;
      remaining_q <= 16'h0000;
      data_q      <= 8'h00;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            src_q       <= src_addr;
            dst_q       <= dst_addr;
            remaining_q <= length;
            // In fill mode the data register simply holds the fill byte throughout.
            if (fill_sel)
              data_q <= fill_value;
          end
        end
        READ_WAIT: data_q <= bus_data_in;
        WRITE_HOLD: begin
          if (!fill_q)
            src_q <= src_q + 16'd1;
          dst_q       <= dst_q + 16'd1;
          remaining_q <= remaining_q - 16'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d          = state_q;
    bus_address      = 16'h0000;
    bus_data_out     = 8'h00;
    bus_write_enable = 1'b0;
    busy             = 1'b1;
    done             = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (length == 16'd0)
            state_d = DONE;
          else if (fill_sel)
            state_d = WRITE;
          else
            state_d = READ_ADDR;
        end
      end
      READ_ADDR: begin
        bus_address = src_q;
        state_d     = READ_WAIT;
      end
      READ_WAIT: begin
        bus_address = src_q;
        state_d     = WRITE;
      end
      WRITE: begin
        bus_address      = dst_q;
        bus_data_out     = data_q;
        bus_write_enable = 1'b1;
        state_d          = WRITE_HOLD;
      end
      WRITE_HOLD: begin
        bus_address  = dst_q;
        bus_data_out = data_q;
        // Count is decremented on this same edge, so 1 here means the last byte.
        if (remaining_q == 16'd1)
          state_d = DONE;
        else if (fill_q)
          state_d = WRITE;
        else
          state_d = READ_ADDR;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_copy.sv
// Self-checking bench for dma_copy: memory bus model with ROM at 0x4000-0x7FFF,
// byte-level reference model, directed and randomized transfers.
module tb_dma_copy;

`ifdef DMA_FILL_EN
  localparam bit FILL_ON = 1'b1;
`else
  localparam bit FILL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] src_addr = '0, dst_addr = '0, length = '0;
  logic [15:0] bus_address;
  logic [7:0]  bus_data_out;
  logic [7:0]  bus_data_in = '0;
  logic        bus_write_enable, busy, done;
  logic        fill_mode = 1'b0;
  logic [7:0]  fill_value = '0;

  int vectors = 0;
  int miscompares = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] addr_log [$];

  dma_copy dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .bus_address(bus_address), .bus_data_out(bus_data_out),
    .bus_data_in(bus_data_in), .bus_write_enable(bus_write_enable),
    .busy(busy), .done(done),
    .fill_mode(fill_mode), .fill_value(fill_value)
  );

  always #5 clk = ~clk;

  function automatic bit writable(input logic [15:0] a);
    return !(a >= 16'h4000 && a <= 16'h7FFF);
  endfunction

  // Memory bus: registered read, registered write, ROM window ignores writes.
  always @(posedge clk) begin
    bus_data_in <= mem[bus_address];
    if (bus_write_enable && writable(bus_address))
      mem[bus_address] = bus_data_out;
  end

  always @(posedge clk) begin
    if (bus_write_enable) we_cnt++;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input string tag);
    int diffs = 0;
    for (int i = 0; i < 65536; i++)
      if (mem[i] !== ref_mem[i]) diffs++;
    check(tag, diffs, 0);
  endtask

  task automatic model_xfer(input logic [15:0] s, input logic [15:0] d, input int n,
                            input bit fill_eff, input logic [7:0] fv);
    logic [15:0] sa, da;
    for (int i = 0; i < n; i++) begin
      sa = s + 16'(i);
      da = d + 16'(i);
      if (writable(da)) ref_mem[da] = fill_eff ? fv : ref_mem[sa];
    end
  endtask

  task automatic run_xfer(input string tag, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] n, input bit fm, input logic [7:0] fv,
                          input bit poke);
    int cyc, exp_cyc;
    bit fill_eff;
    fill_eff = fm && FILL_ON;
    exp_cyc  = (n == 0) ? 1 : (fill_eff ? 2 * int'(n) + 1 : 4 * int'(n) + 1);
    model_xfer(s, d, int'(n), fill_eff, fv);
    @(negedge clk);
    src_addr = s; dst_addr = d; length = n; fill_mode = fm; fill_value = fv;
    start = 1'b1;
    we_cnt = 0; done_cnt = 0;
    addr_log.delete();
    cyc = 0;
    while (cyc < exp_cyc + 20) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      addr_log.push_back(bus_address);
      if (cyc == 1) check({tag, "_busy"}, busy, 1'b1);
      if (poke && cyc == 3) begin
        start = 1'b1;
        src_addr = 16'($urandom); dst_addr = 16'($urandom); length = 16'd5;
      end
      if (done) break;
    end
    check({tag, "_latency"}, cyc, exp_cyc);
    check({tag, "_we_pulses"}, we_cnt, int'(n));
    @(negedge clk);
    check({tag, "_idle_after"}, {busy, done}, 2'b00);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check_mem({tag, "_mem"});
  endtask

  initial begin
    int cyc;
    logic [15:0] rs, rd, rn;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    #3;
    check("reset_outputs", {busy, done, bus_write_enable, bus_address, bus_data_out},
          {3'b000, 16'h0000, 8'h00});
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Four known bytes, 17-cycle latency, exact destination contents.
    mem[16'h0010] = 8'd11; mem[16'h0011] = 8'd22; mem[16'h0012] = 8'd33; mem[16'h0013] = 8'd44;
    for (int i = 16'h10; i <= 16'h13; i++) ref_mem[i] = mem[i];
    run_xfer("copy4", 16'h0010, 16'h0100, 16'd4, 1'b0, 8'h00, 1'b0);
    check("copy4_bytes", {mem[16'h0100], mem[16'h0101], mem[16'h0102], mem[16'h0103]},
          {8'd11, 8'd22, 8'd33, 8'd44});

    run_xfer("rom8", 16'h4000, 16'h0000, 16'd8, 1'b0, 8'h00, 1'b1);
    run_xfer("len0", 16'h1111, 16'h2222, 16'd0, 1'b0, 8'h00, 1'b0);

    run_xfer("wrap", 16'hFFFF, 16'h1234, 16'd2, 1'b0, 8'h00, 1'b0);
    check("wrap_rd0", addr_log[0], 16'hFFFF);
    check("wrap_rd0_hold", addr_log[1], 16'hFFFF);
    check("wrap_rd1", addr_log[4], 16'h0000);

    // In the default build fill_mode is ignored and this is a 13-cycle copy.
    run_xfer("fill3", 16'h0500, 16'h0020, 16'd3, 1'b1, 8'hA5, 1'b1);

    // Reset during the WRITE of the third byte of eight (cycle 11).
    model_xfer(16'h0200, 16'h0300, 2, 1'b0, 8'h00);
    @(negedge clk);
    src_addr = 16'h0200; dst_addr = 16'h0300; length = 16'd8; fill_mode = 1'b0;
    start = 1'b1; done_cnt = 0;
    cyc = 0;
    while (cyc < 11) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    check("abort_in_write", bus_write_enable, 1'b1);
    reset = 1'b1;
    #1;
    check("abort_outputs", {busy, done, bus_write_enable, bus_address, bus_data_out},
          {3'b000, 16'h0000, 8'h00});
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check_mem("abort_mem");

    for (int k = 0; k < 6; k++) begin
      rs = 16'($urandom);
      rd = 16'($urandom);
      rn = 16'($urandom_range(0, 7));
      run_xfer($sformatf("rand%0d", k), rs, rd, rn, 1'($urandom), 8'($urandom),
               (rn >= 2) && 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
